mac_result_writeback: RTL

- Output stage of the FMA/MAC datapath. Sits directly downstream of the rounding stage.
- Registers the rounded sign/exponent/mantissa and the raw exception indications, and packs them into an IEEE-754 single word.
- Derives RISC-V per-operation flags and exposes results through a 2-entry valid/ready buffer toward the register-file writeback port.
- Accumulates sticky fflags for the FCSR as results retire.

---
 rtl/mac_result_writeback.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mac_result_writeback.sv
// Output stage of the FMA/MAC datapath: packs rounded results, derives RISC-V flags,
// buffers two entries toward writeback and accumulates sticky fflags.
// Optional retired-result counter enabled by defining MAC_WB_RETIRE_CNT_EN.
`timescale 1ns/1ps
module mac_result_writeback #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_TAG  = 5,
  parameter logic [PARM_EXP+PARM_MANT:0] PARM_CANON_NAN = 32'h7FC0_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          In_valid_i,
  output logic                          In_ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic [PARM_MANT-1:0]          Mant_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  input  logic                          Inexact_i,
  input  logic [PARM_TAG-1:0]           Tag_i,
  output logic                          Out_valid_o,
  input  logic                          Out_ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [PARM_TAG-1:0]           Tag_o,
  output logic [4:0]                    Flags_o,
  output logic [4:0]                    Fflags_o,
  input  logic                          Fflags_wr_i,
  input  logic [4:0]                    Fflags_wdata_i,
  input  logic                          Fflags_clr_i,
  output logic [31:0]                   Retired_cnt_o
);

  localparam int unsigned W = PARM_EXP + PARM_MANT + 1;

  typedef struct packed {
    logic [W-1:0]        result;
    logic [PARM_TAG-1:0] tag;
    logic [4:0]          flags;
  } entry_t;

  entry_t     head_q, head_d, tail_q, tail_d, new_entry_c;
  logic [1:0] count_q, count_d;
  logic       valid_q, ready_q;
  logic [4:0] fflags_q, fflags_d;
  logic       push_c, pop_c;

  assign push_c = In_valid_i & ready_q;
  assign pop_c  = valid_q & Out_ready_i;

  // Pack the incoming result; any NaN collapses to the canonical quiet NaN.
  always_comb begin
    new_entry_c.result = {Sign_i, Exp_i, Mant_i};
    if ((&Exp_i) && (|Mant_i)) begin
      new_entry_c.result = PARM_CANON_NAN;
    end
    new_entry_c.tag   = Tag_i;
    new_entry_c.flags = {Invalid_i,
                         1'b0,
                         Overflow_i & ~Invalid_i,
                         Underflow_i & Inexact_i & ~Invalid_i,
                         (Inexact_i | Overflow_i) & ~Invalid_i};
  end

  // Two-entry FIFO: head drives the outputs directly, tail holds the second entry.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push_c) begin
          head_d  = new_entry_c;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push_c && pop_c) begin
          head_d = new_entry_c;
        end else if (push_c) begin
          tail_d  = new_entry_c;
          count_d = 2'd2;
        end else if (pop_c) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop_c) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // CSR write beats clear; a retiring op's flags are always merged in.
  always_comb begin
    fflags_d = Fflags_wr_i ? Fflags_wdata_i : (Fflags_clr_i ? 5'd0 : fflags_q);
    if (pop_c) begin
      fflags_d = fflags_d | head_q.flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      fflags_q <= 5'd0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= (count_d != 2'd0);
      ready_q  <= (count_d != 2'd2);
      fflags_q <= fflags_d;
    end
  end

  assign In_ready_o  = ready_q;
  assign Out_valid_o = valid_q;
  assign Result_o    = head_q.result;
  assign Tag_o       = head_q.tag;
  assign Flags_o     = head_q.flags;
  assign Fflags_o    = fflags_q;

`ifdef MAC_WB_RETIRE_CNT_EN
  logic [31:0] ret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt_q <= 32'd0;
    end else if (pop_c) begin
      ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign Retired_cnt_o = ret_cnt_q;
`else
  assign Retired_cnt_o = 32'd0;
`endif

endmodule
